// File: rtl/mc_control_fsm_if.sv
// Handshake and control bundle between mc_control_fsm, the memories and the datapath.
// master = control FSM side, slave = datapath / memory side.
interface mc_control_fsm_if #(
    parameter int unsigned CNT_W = 32
);
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             dmem_req;
    logic             dmem_we;
    logic             ir_write;
    logic             pc_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic             alu_src;
    logic [3:0]       alu_op;
    logic             branch;
    logic             jump;
    logic [1:0]       pc_src;
    logic [2:0]       state;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] instret;

    modport master (
        input  opcode, funct3, funct7, imem_ready, dmem_ready,
        output imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write, mem_to_reg,
               alu_src, alu_op, branch, jump, pc_src, state, trap, trap_cause, instret
    );

    modport slave (
        output opcode, funct3, funct7, imem_ready, dmem_ready,
        input  imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write, mem_to_reg,
               alu_src, alu_op, branch, jump, pc_src, state, trap, trap_cause, instret
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with memory-wait
// timeout, sticky trap and retired-instruction counter.
module mc_control_fsm #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    mc_control_fsm_if.master bus
);
    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd7
    } state_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    state_e           r_state, w_state_nxt;
    logic [7:0]       r_wait, w_wait_nxt;
    logic [6:0]       r_opcode;
    logic [2:0]       r_funct3;
    logic [6:0]       r_funct7;
    logic             r_trap;
    logic [1:0]       r_cause, w_cause_nxt;
    logic [CNT_W-1:0] r_instret;
    logic             w_retire;
    logic [3:0]       w_alu_op;

    logic w_is_r, w_is_imm, w_is_load, w_is_store, w_is_branch;
    logic w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_legal, w_timeout;

    assign w_is_r      = (r_opcode == OpR);
    assign w_is_imm    = (r_opcode == OpImm);
    assign w_is_load   = (r_opcode == OpLoad);
    assign w_is_store  = (r_opcode == OpStore);
    assign w_is_branch = (r_opcode == OpBranch);
    assign w_is_jal    = (r_opcode == OpJal);
    assign w_is_jalr   = (r_opcode == OpJalr);
    assign w_is_lui    = (r_opcode == OpLui);
    assign w_is_auipc  = (r_opcode == OpAuipc);
    assign w_legal     = w_is_r | w_is_imm | w_is_load | w_is_store | w_is_branch |
                         w_is_jal | w_is_jalr | w_is_lui | w_is_auipc;
    assign w_timeout   = (r_wait == TimeoutCnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait    <= '0;
            r_opcode  <= '0;
            r_funct3  <= '0;
            r_funct7  <= '0;
            r_trap    <= 1'b0;
            r_cause   <= '0;
            r_instret <= '0;
        end else begin
            r_wait  <= w_wait_nxt;
            r_trap  <= r_trap | (w_state_nxt == StTrap);
            r_cause <= w_cause_nxt;
            if (r_state == StFetch && bus.imem_ready) begin
                r_opcode <= bus.opcode;
                r_funct3 <= bus.funct3;
                r_funct7 <= bus.funct7;
            end
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    // A ready arriving on the timeout cycle takes priority over the trap.
    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        w_retire    = 1'b0;
        unique case (r_state)
            StFetch: begin
                if (bus.imem_ready) begin
                    w_state_nxt = StDecode;
                end else if (w_timeout) begin
                    w_state_nxt = StTrap;
                    w_cause_nxt = 2'b10;
                end
            end
            StDecode: begin
                if (w_legal) begin
                    w_state_nxt = StExec;
                end else begin
                    w_state_nxt = StTrap;
                    w_cause_nxt = 2'b01;
                end
            end
            StExec: begin
                if (w_is_branch) begin
                    w_state_nxt = StFetch;
                    w_retire    = 1'b1;
                end else if (w_is_load || w_is_store) begin
                    w_state_nxt = StMem;
                end else begin
                    w_state_nxt = StWb;
                end
            end
            StMem: begin
                if (bus.dmem_ready) begin
                    w_state_nxt = w_is_store ? StFetch : StWb;
                    w_retire    = w_is_store;
                end else if (w_timeout) begin
                    w_state_nxt = StTrap;
                    w_cause_nxt = 2'b11;
                end
            end
            StWb: begin
                w_state_nxt = StFetch;
                w_retire    = 1'b1;
            end
            StTrap:  w_state_nxt = StTrap;
            default: w_state_nxt = StTrap;
        endcase
        w_wait_nxt = '0;
        if (w_state_nxt == r_state && (r_state == StFetch || r_state == StMem)) begin
            w_wait_nxt = r_wait + 8'd1;
        end
    end

    always_comb begin
        w_alu_op = 4'b0000;
        if (w_is_r) begin
            unique case ({r_funct3, r_funct7})
                {3'b000, 7'h20}: w_alu_op = 4'b0001;
                {3'b001, 7'h00}: w_alu_op = 4'b0101;
                {3'b010, 7'h00}: w_alu_op = 4'b1000;
                {3'b011, 7'h00}: w_alu_op = 4'b1001;
                {3'b100, 7'h00}: w_alu_op = 4'b0100;
                {3'b101, 7'h00}: w_alu_op = 4'b0110;
                {3'b101, 7'h20}: w_alu_op = 4'b0111;
                {3'b110, 7'h00}: w_alu_op = 4'b0011;
                {3'b111, 7'h00}: w_alu_op = 4'b0010;
                default:         w_alu_op = 4'b0000;
            endcase
        end else if (w_is_imm) begin
            unique case (r_funct3)
                3'b001:  w_alu_op = 4'b0101;
                3'b010:  w_alu_op = 4'b1000;
                3'b011:  w_alu_op = 4'b1001;
                3'b100:  w_alu_op = 4'b0100;
                3'b101:  w_alu_op = (r_funct7 == 7'h20) ? 4'b0111 : 4'b0110;
                3'b110:  w_alu_op = 4'b0011;
                3'b111:  w_alu_op = 4'b0010;
                default: w_alu_op = 4'b0000;
            endcase
        end else if (w_is_branch) begin
            w_alu_op = 4'b0001;
        end
    end

    always_comb begin
        bus.imem_req   = 1'b0;
        bus.dmem_req   = 1'b0;
        bus.dmem_we    = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src    = 1'b0;
        bus.alu_op     = 4'b0000;
        bus.branch     = 1'b0;
        bus.jump       = 1'b0;
        bus.pc_src     = 2'b00;
        unique case (r_state)
            StFetch: begin
                bus.imem_req = 1'b1;
                bus.ir_write = bus.imem_ready;
            end
            StExec: begin
                bus.alu_op  = w_alu_op;
                bus.alu_src = w_is_imm | w_is_load | w_is_store | w_is_jalr | w_is_lui | w_is_auipc;
                if (w_is_branch) begin
                    bus.branch   = 1'b1;
                    bus.pc_src   = 2'b01;
                    bus.pc_write = 1'b1;
                end
            end
            StMem: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = w_is_store;
                bus.pc_write = w_is_store & bus.dmem_ready;
            end
            StWb: begin
                bus.reg_write  = 1'b1;
                bus.pc_write   = 1'b1;
                bus.mem_to_reg = w_is_load;
                bus.jump       = w_is_jal | w_is_jalr;
                bus.pc_src     = w_is_jal ? 2'b01 : (w_is_jalr ? 2'b10 : 2'b00);
            end
            default: ;
        endcase
        bus.state      = r_state;
        bus.trap       = r_trap;
        bus.trap_cause = r_cause;
        bus.instret    = r_instret;
    end
endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: hand-written instruction table, corner sequences and
// randomized instructions, each checked cycle by cycle against a transaction-level model.
module tb_mc_control_fsm;
    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned CNT_W   = 32;
    localparam int          NVEC    = 18;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] LEGAL [9] = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                                         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    // ALU op selected by funct3 when no funct7 modifier applies
    localparam logic [3:0] BASE_OP [8] = '{4'b0000, 4'b0101, 4'b1000, 4'b1001,
                                           4'b0100, 4'b0110, 4'b0011, 4'b0010};

    typedef struct packed {
        logic [2:0] state;
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_op;
        logic       branch;
        logic       jump;
        logic [1:0] pc_src;
        logic       trap;
        logic [1:0] trap_cause;
    } obs_t;

    typedef struct {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        int         idelay;
        int         ddelay;
        logic [3:0] alu_op;
        logic       alu_src;
        logic [2:0] ret_st;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    int               errors = 0;
    int               checks = 0;
    logic [CNT_W-1:0] m_instret = '0;
    logic             m_trapped = 1'b0;
    logic [1:0]       m_cause = 2'b00;
    vec_t             vecs [NVEC];

    mc_control_fsm_if #(.CNT_W(CNT_W)) bus ();

    mc_control_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    function automatic obs_t sample();
        obs_t a;
        a.state      = bus.state;
        a.imem_req   = bus.imem_req;
        a.dmem_req   = bus.dmem_req;
        a.dmem_we    = bus.dmem_we;
        a.ir_write   = bus.ir_write;
        a.pc_write   = bus.pc_write;
        a.reg_write  = bus.reg_write;
        a.mem_to_reg = bus.mem_to_reg;
        a.alu_src    = bus.alu_src;
        a.alu_op     = bus.alu_op;
        a.branch     = bus.branch;
        a.jump       = bus.jump;
        a.pc_src     = bus.pc_src;
        a.trap       = bus.trap;
        a.trap_cause = bus.trap_cause;
        return a;
    endfunction

    function automatic obs_t base(input logic [2:0] st);
        obs_t e;
        e            = '0;
        e.state      = st;
        e.trap       = m_trapped;
        e.trap_cause = m_cause;
        return e;
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        for (int i = 0; i < 9; i++) if (LEGAL[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] ref_alu(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7);
        if (op == OP_R) begin
            if (f7 == 7'h00) return BASE_OP[f3];
            if (f7 == 7'h20 && f3 == 3'b000) return 4'b0001;
            if (f7 == 7'h20 && f3 == 3'b101) return 4'b0111;
            return 4'b0000;
        end
        if (op == OP_IMM) return (f3 == 3'b101 && f7 == 7'h20) ? 4'b0111 : BASE_OP[f3];
        if (op == OP_BRANCH) return 4'b0001;
        return 4'b0000;
    endfunction

    function automatic logic ref_src(input logic [6:0] op);
        return (op == OP_IMM) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_JALR) ||
               (op == OP_LUI) || (op == OP_AUIPC);
    endfunction

    task automatic check_obs(input string name, input obs_t exp);
        obs_t act;
        act = sample();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic dr, input logic valid, input logic [6:0] op,
                         input logic [2:0] f3, input logic [6:0] f7);
        @(negedge clk);
        bus.imem_ready = ir;
        bus.dmem_ready = dr;
        bus.opcode     = valid ? op : 7'($urandom);
        bus.funct3     = valid ? f3 : 3'($urandom);
        bus.funct7     = valid ? f7 : 7'($urandom);
        #1;
    endtask

    task automatic drive_junk();
        drive(1'($urandom), 1'($urandom), 1'b0, 7'd0, 3'd0, 7'd0);
    endtask

    task automatic do_reset();
        obs_t e;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        #2 rst_n = 1'b0;
        m_instret = '0;
        m_trapped = 1'b0;
        m_cause   = 2'b00;
        #1;
        e = base(3'd0);
        e.imem_req = 1'b1;
        check_obs("reset outputs", e);
        check_val("reset instret", bus.instret, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Walks one instruction through the DUT, comparing every cycle with the model.
    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input int idelay, input int ddelay,
                             input logic [3:0] exp_alu, input logic exp_src,
                             output logic [2:0] last_st);
        obs_t e;
        logic ld, st, br, jal, jalr;
        ld   = (op == OP_LOAD);
        st   = (op == OP_STORE);
        br   = (op == OP_BRANCH);
        jal  = (op == OP_JAL);
        jalr = (op == OP_JALR);
        last_st = 3'd0;
        for (int k = 0; k <= int'(TIMEOUT); k++) begin
            drive(k == idelay, 1'($urandom), k == idelay, op, f3, f7);
            if (k == 0) check_val({name, " instret"}, bus.instret, m_instret);
            e = base(3'd0);
            e.imem_req = 1'b1;
            e.ir_write = (k == idelay);
            check_obs($sformatf("%s fetch%0d", name, k), e);
            last_st = bus.state;
            if (k == idelay) break;
            if (k == int'(TIMEOUT)) begin
                m_trapped = 1'b1;
                m_cause   = 2'b10;
                return;
            end
        end
        drive_junk();
        check_obs({name, " decode"}, base(3'd1));
        last_st = bus.state;
        if (!is_legal(op)) begin
            m_trapped = 1'b1;
            m_cause   = 2'b01;
            return;
        end
        drive_junk();
        e = base(3'd2);
        e.alu_op  = exp_alu;
        e.alu_src = exp_src;
        if (br) begin
            e.branch   = 1'b1;
            e.pc_src   = 2'b01;
            e.pc_write = 1'b1;
        end
        check_obs({name, " exec"}, e);
        last_st = bus.state;
        if (br) begin
            m_instret = m_instret + 1;
            return;
        end
        if (ld || st) begin
            for (int k = 0; k <= int'(TIMEOUT); k++) begin
                drive(1'($urandom), k == ddelay, 1'b0, 7'd0, 3'd0, 7'd0);
                e = base(3'd3);
                e.dmem_req = 1'b1;
                e.dmem_we  = st;
                e.pc_write = st && (k == ddelay);
                check_obs($sformatf("%s mem%0d", name, k), e);
                last_st = bus.state;
                if (k == ddelay) break;
                if (k == int'(TIMEOUT)) begin
                    m_trapped = 1'b1;
                    m_cause   = 2'b11;
                    return;
                end
            end
            if (st) begin
                m_instret = m_instret + 1;
                return;
            end
        end
        drive_junk();
        e = base(3'd4);
        e.reg_write  = 1'b1;
        e.pc_write   = 1'b1;
        e.mem_to_reg = ld;
        e.jump       = jal || jalr;
        e.pc_src     = jal ? 2'b01 : (jalr ? 2'b10 : 2'b00);
        check_obs({name, " wb"}, e);
        last_st = bus.state;
        m_instret = m_instret + 1;
    endtask

    task automatic trap_hold(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            drive_junk();
            check_obs($sformatf("%s hold%0d", name, i), base(3'd7));
        end
        check_val({name, " instret held"}, bus.instret, m_instret);
    endtask

    initial begin
        logic [2:0] st;
        logic [6:0] op, f7;
        logic [2:0] f3;
        int         id, dd, r;

        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.opcode     = '0;
        bus.funct3     = '0;
        bus.funct7     = '0;
        vecs = '{
            '{OP_R,      3'b000, 7'h00,  0,  0, 4'b0000, 1'b0, 3'd4},
            '{OP_R,      3'b000, 7'h20,  2,  0, 4'b0001, 1'b0, 3'd4},
            '{OP_R,      3'b101, 7'h20,  1,  0, 4'b0111, 1'b0, 3'd4},
            '{OP_R,      3'b011, 7'h00,  0,  0, 4'b1001, 1'b0, 3'd4},
            '{OP_R,      3'b000, 7'h01,  0,  0, 4'b0000, 1'b0, 3'd4},
            '{OP_IMM,    3'b110, 7'h15,  0,  0, 4'b0011, 1'b1, 3'd4},
            '{OP_IMM,    3'b111, 7'h00,  0,  0, 4'b0010, 1'b1, 3'd4},
            '{OP_IMM,    3'b101, 7'h20,  0,  0, 4'b0111, 1'b1, 3'd4},
            '{OP_IMM,    3'b101, 7'h00,  0,  0, 4'b0110, 1'b1, 3'd4},
            '{OP_LOAD,   3'b010, 7'h00,  0,  3, 4'b0000, 1'b1, 3'd4},
            '{OP_STORE,  3'b010, 7'h00,  0,  0, 4'b0000, 1'b1, 3'd3},
            '{OP_BRANCH, 3'b000, 7'h00,  0,  0, 4'b0001, 1'b0, 3'd2},
            '{OP_JAL,    3'b000, 7'h00,  0,  0, 4'b0000, 1'b0, 3'd4},
            '{OP_JALR,   3'b000, 7'h00,  0,  0, 4'b0000, 1'b1, 3'd4},
            '{OP_LUI,    3'b000, 7'h00,  0,  0, 4'b0000, 1'b1, 3'd4},
            '{OP_AUIPC,  3'b000, 7'h00,  0,  0, 4'b0000, 1'b1, 3'd4},
            '{OP_R,      3'b000, 7'h00, 15,  0, 4'b0000, 1'b0, 3'd4},
            '{OP_LOAD,   3'b010, 7'h00,  0, 15, 4'b0000, 1'b1, 3'd4}
        };

        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            run_instr($sformatf("vec%0d", i), vecs[i].opcode, vecs[i].funct3, vecs[i].funct7,
                      vecs[i].idelay, vecs[i].ddelay, vecs[i].alu_op, vecs[i].alu_src, st);
            check_val($sformatf("vec%0d retire state", i), 32'(st), 32'(vecs[i].ret_st));
        end
        @(posedge clk);
        #1 check_val("table instret", bus.instret, 32'(NVEC));

        // Store then branch: both retire without a WB cycle.
        do_reset();
        run_instr("sw", OP_STORE, 3'b010, 7'h00, 0, 2, 4'b0000, 1'b1, st);
        run_instr("beq", OP_BRANCH, 3'b000, 7'h00, 1, 0, 4'b0001, 1'b0, st);
        @(posedge clk);
        #1 check_val("sw+beq instret", bus.instret, 32'd2);

        do_reset();
        run_instr("illegal", 7'b1111111, 3'b000, 7'h00, 0, 0, 4'b0000, 1'b0, st);
        trap_hold("illegal", 20);
        check_val("illegal cause", 32'(bus.trap_cause), 32'd1);

        do_reset();
        run_instr("imem_to", OP_R, 3'b000, 7'h00, 1000, 0, 4'b0000, 1'b0, st);
        trap_hold("imem_to", 5);
        check_val("imem_to cause", 32'(bus.trap_cause), 32'd2);

        do_reset();
        run_instr("dmem_to", OP_LOAD, 3'b010, 7'h00, 0, 1000, 4'b0000, 1'b1, st);
        trap_hold("dmem_to", 5);

        // Asynchronous reset in the middle of a data access.
        do_reset();
        run_instr("pre_add", OP_R, 3'b000, 7'h00, 0, 0, 4'b0000, 1'b0, st);
        drive(1'b1, 1'b0, 1'b1, OP_LOAD, 3'b010, 7'h00);
        drive_junk();
        drive_junk();
        drive(1'b0, 1'b0, 1'b0, 7'd0, 3'd0, 7'd0);
        check_val("mid_mem state", 32'(bus.state), 32'd3);
        check_val("mid_mem dmem_req", 32'(bus.dmem_req), 32'd1);
        check_val("mid_mem instret", bus.instret, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("async rst state", 32'(bus.state), 32'd0);
        check_val("async rst dmem_req", 32'(bus.dmem_req), 32'd0);
        check_val("async rst imem_req", 32'(bus.imem_req), 32'd1);
        check_val("async rst instret", bus.instret, 32'd0);
        m_instret = '0;
        m_trapped = 1'b0;
        m_cause   = 2'b00;
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_instr("post_rst", OP_IMM, 3'b110, 7'h00, 0, 0, 4'b0011, 1'b1, st);

        for (int n = 0; n < 80; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : LEGAL[$urandom_range(0, 8)];
            f3 = 3'($urandom);
            r  = int'($urandom_range(0, 3));
            f7 = (r == 0) ? 7'h00 : ((r == 1) ? 7'h20 : 7'($urandom));
            r  = int'($urandom_range(0, 49));
            id = (r == 0) ? 20 : ((r == 1) ? 15 : int'($urandom_range(0, 3)));
            r  = int'($urandom_range(0, 29));
            dd = (r == 0) ? 20 : ((r == 1) ? 15 : int'($urandom_range(0, 4)));
            run_instr($sformatf("rnd%0d", n), op, f3, f7, id, dd, ref_alu(op, f3, f7),
                      ref_src(op), st);
            if (m_trapped) begin
                trap_hold($sformatf("rnd%0d", n), 4);
                do_reset();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
